// File: rtl/pose_pkg.sv
// Shared key, axis and scan-code definitions for the PS/2 driven pose command scheduler.
package pose_pkg;

  localparam int NUM_KEYS = 12;

  typedef enum logic [3:0] {
    KEY_W, KEY_A, KEY_S, KEY_D, KEY_SHIFT, KEY_SPACE,
    KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT, KEY_IN, KEY_OUT
  } key_e;

  typedef enum logic [2:0] {
    AXIS_X, AXIS_Y, AXIS_Z, AXIS_ALPHA, AXIS_BETA, AXIS_GAMMA
  } axis_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SHIFT = 8'h12;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_IN    = 8'h73;
  localparam logic [7:0] SC_OUT   = 8'h70;

  typedef struct packed {
    axis_e axis;
    logic  neg;
  } key_dir_t;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_lookup_t;

  function automatic key_lookup_t lookup_key(input logic [7:0] code);
    lookup_key = '{hit: 1'b1, key: KEY_W};
    case (code)
      SC_W:     lookup_key.key = KEY_W;
      SC_A:     lookup_key.key = KEY_A;
      SC_S:     lookup_key.key = KEY_S;
      SC_D:     lookup_key.key = KEY_D;
      SC_SHIFT: lookup_key.key = KEY_SHIFT;
      SC_SPACE: lookup_key.key = KEY_SPACE;
      SC_UP:    lookup_key.key = KEY_UP;
      SC_DOWN:  lookup_key.key = KEY_DOWN;
      SC_RIGHT: lookup_key.key = KEY_RIGHT;
      SC_LEFT:  lookup_key.key = KEY_LEFT;
      SC_IN:    lookup_key.key = KEY_IN;
      SC_OUT:   lookup_key.key = KEY_OUT;
      default:  lookup_key.hit = 1'b0;
    endcase
  endfunction

  function automatic key_dir_t key_dir(input key_e k);
    case (k)
      KEY_W:     key_dir = '{AXIS_Z, 1'b1};
      KEY_A:     key_dir = '{AXIS_X, 1'b1};
      KEY_S:     key_dir = '{AXIS_Z, 1'b0};
      KEY_D:     key_dir = '{AXIS_X, 1'b0};
      KEY_SHIFT: key_dir = '{AXIS_Y, 1'b1};
      KEY_SPACE: key_dir = '{AXIS_Y, 1'b0};
      KEY_UP:    key_dir = '{AXIS_BETA, 1'b1};
      KEY_DOWN:  key_dir = '{AXIS_BETA, 1'b0};
      KEY_RIGHT: key_dir = '{AXIS_GAMMA, 1'b0};
      KEY_LEFT:  key_dir = '{AXIS_GAMMA, 1'b1};
      KEY_IN:    key_dir = '{AXIS_ALPHA, 1'b1};
      KEY_OUT:   key_dir = '{AXIS_ALPHA, 1'b0};
      default:   key_dir = '{AXIS_X, 1'b0};
    endcase
  endfunction

  // Opposing key drives the same axis in the other direction.
  function automatic key_e opposing(input key_e k);
    case (k)
      KEY_W:     opposing = KEY_S;
      KEY_S:     opposing = KEY_W;
      KEY_A:     opposing = KEY_D;
      KEY_D:     opposing = KEY_A;
      KEY_SHIFT: opposing = KEY_SPACE;
      KEY_SPACE: opposing = KEY_SHIFT;
      KEY_UP:    opposing = KEY_DOWN;
      KEY_DOWN:  opposing = KEY_UP;
      KEY_RIGHT: opposing = KEY_LEFT;
      KEY_LEFT:  opposing = KEY_RIGHT;
      KEY_IN:    opposing = KEY_OUT;
      default:   opposing = KEY_IN;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 make/break decoder maintaining a bitmap of held mapped keys; E0 prefix does not alter mapping.
module ps2_key_decoder
  import pose_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  output logic [11:0] held
);

  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_e;

  dec_state_e  state, state_next;
  logic [11:0] held_next;
  key_lookup_t lk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= D_IDLE;
      held  <= '0;
    end else begin
      state <= state_next;
      held  <= held_next;
    end
  end

  always_comb begin
    state_next = state;
    held_next  = held;
    lk         = lookup_key(scan_code);
    if (scan_valid) begin
      case (state)
        D_IDLE, D_EXT: begin
          if (scan_code == SC_EXT) begin
            state_next = D_EXT;
          end else if (scan_code == SC_BRK) begin
            state_next = (state == D_EXT) ? D_EXT_BRK : D_BRK;
          end else begin
            if (lk.hit) held_next[lk.key] = 1'b1;
            state_next = D_IDLE;
          end
        end
        default: begin
          if (lk.hit) held_next[lk.key] = 1'b0;
          state_next = D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pose_cmd_scheduler.sv
// Slot-paced round-robin command scheduler for held pose keys.
// Optional POSE_SCHED_ACCEL_EN: quarter slot period once held has been steady for 16 slots.
module pose_cmd_scheduler
  import pose_pkg::*;
#(
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_axis,
  output logic        cmd_neg,
  output logic [11:0] held,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST_FULL = CW'(TICK_CYCLES - 1);

  typedef enum logic {S_WAIT, S_ISSUE} sched_state_e;

  sched_state_e   state, state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  last;
  logic           slot;
  key_e           ptr, pick;
  logic           found;
  logic           issue;
  logic [11:0]    eligible;
  logic [4:0]     idx;
  key_dir_t       dir;

  ps2_key_decoder u_dec (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .held       (held)
  );

`ifdef POSE_SCHED_ACCEL_EN
  localparam logic [CW-1:0] LAST_FAST = CW'(TICK_CYCLES / 4 - 1);
  logic [11:0] held_q;
  logic [4:0]  stable;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      held_q <= '0;
      stable <= '0;
    end else begin
      held_q <= held;
      if (held != held_q) begin
        stable <= '0;
      end else if (slot) begin
        if (held == '0)          stable <= '0;
        else if (stable != 5'd16) stable <= stable + 5'd1;
      end
    end
  end

  assign last = (stable == 5'd16) ? LAST_FAST : LAST_FULL;
`else
  assign last = LAST_FULL;
`endif

  // Counter may sit above a freshly shortened period, so compare with >=.
  assign slot      = (cnt >= last);
  assign cmd_valid = (state == S_ISSUE);
  assign issue     = (state == S_WAIT) && slot && found;
  assign dir       = key_dir(pick);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      eligible[i] = held[i] & ~held[opposing(key_e'(4'(i)))];
  end

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int off = 1; off <= NUM_KEYS; off++) begin
      idx = {1'b0, ptr} + 5'(off);
      if (idx >= 5'(NUM_KEYS)) idx = idx - 5'(NUM_KEYS);
      if (!found && eligible[idx[3:0]]) begin
        found = 1'b1;
        pick  = key_e'(idx[3:0]);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:  if (issue) state_next = S_ISSUE;
      default: if (cmd_ready) state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_WAIT;
      cnt      <= '0;
      ptr      <= KEY_OUT;
      cmd_axis <= '0;
      cmd_neg  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= slot ? '0 : cnt + 1'b1;
      if (issue) begin
        cmd_axis <= dir.axis;
        cmd_neg  <= dir.neg;
        ptr      <= pick;
      end
      if ((state == S_ISSUE) && slot && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pose_cmd_scheduler.sv
// Self-checking bench for pose_cmd_scheduler (TICK_CYCLES=8) against a transaction-level key/slot model.
module tb_pose_cmd_scheduler;

  localparam int TICK = 8;
  localparam int AXIS_TAB [12] = '{2, 0, 2, 0, 1, 1, 4, 4, 5, 5, 3, 3};
  localparam int NEG_TAB  [12] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0};
  localparam int OPP_TAB  [12] = '{2, 3, 0, 1, 5, 4, 7, 6, 9, 8, 11, 10};
  localparam logic [7:0] CODES [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h12, 8'h29,
                                        8'h75, 8'h72, 8'h74, 8'h6B, 8'h73, 8'h70};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  scan_code = '0;
  logic        scan_valid = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd_axis;
  logic        cmd_neg;
  logic [11:0] held;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pose_cmd_scheduler #(.TICK_CYCLES(TICK)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_axis   (cmd_axis),
    .cmd_neg    (cmd_neg),
    .held       (held),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: keys held as a set, one pending command, slots every period cycles.
  logic        m_valid;
  logic [2:0]  m_axis;
  logic        m_neg;
  logic [11:0] m_held;
  logic [7:0]  m_drop;
  int          m_cnt, m_last, m_period, m_stable;
  bit          m_slot, m_pref_brk, m_done;
  logic [11:0] m_old, m_prev;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid = 0; m_axis = 0; m_neg = 0; m_held = '0; m_drop = 0;
      m_cnt = 0; m_last = 11; m_stable = 0; m_pref_brk = 0; m_prev = '0;
    end else begin
      m_old = m_held;
`ifdef POSE_SCHED_ACCEL_EN
      m_period = (m_stable >= 16) ? TICK / 4 : TICK;
`else
      m_period = TICK;
`endif
      m_slot = (m_cnt >= m_period - 1);
      m_cnt  = m_slot ? 0 : m_cnt + 1;
      if (m_valid) begin
        if (m_slot && m_drop != 8'd255) m_drop = m_drop + 8'd1;
        if (cmd_ready) m_valid = 0;
      end else if (m_slot) begin
        m_done = 0;
        for (int off = 1; off <= 12; off++) begin
          int k;
          k = (m_last + off) % 12;
          if (!m_done && m_old[k] && !m_old[OPP_TAB[k]]) begin
            m_done = 1; m_valid = 1; m_last = k;
            m_axis = 3'(AXIS_TAB[k]); m_neg = NEG_TAB[k][0];
          end
        end
      end
      if (m_old != m_prev) m_stable = 0;
      else if (m_slot) m_stable = (m_old == 0) ? 0 : ((m_stable < 16) ? m_stable + 1 : 16);
      m_prev = m_old;
      if (scan_valid) begin
        if (scan_code == 8'hE0 && !m_pref_brk) begin
        end else if (scan_code == 8'hF0 && !m_pref_brk) begin
          m_pref_brk = 1;
        end else begin
          for (int k = 0; k < 12; k++)
            if (CODES[k] == scan_code) m_held[k] = !m_pref_brk;
          m_pref_brk = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 5;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.cmd_valid got=%0b exp=0", cmd_valid); end
    if (cmd_axis !== 3'd0)  begin n_fail++; $display("[TB] FAIL reset.cmd_axis got=%0d exp=0", cmd_axis); end
    if (cmd_neg !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset.cmd_neg got=%0b exp=0", cmd_neg); end
    if (held !== 12'h000)   begin n_fail++; $display("[TB] FAIL reset.held got=%h exp=000", held); end
    if (drop_cnt !== 8'd0)  begin n_fail++; $display("[TB] FAIL reset.drop_cnt got=%0d exp=0", drop_cnt); end
    resetn = 1'b1;
  endtask

  task automatic test_single_key;
    int hs = 0;
    send_byte(8'h1D);
    repeat (40) begin
      @(negedge clk);
      n_tests += 3;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL single.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (held !== m_held)       begin n_fail++; $display("[TB] FAIL single.held got=%h exp=%h", held, m_held); end
      if (drop_cnt !== m_drop)   begin n_fail++; $display("[TB] FAIL single.drop got=%0d exp=%0d", drop_cnt, m_drop); end
      if (m_valid) begin
        n_tests += 2;
        if (cmd_axis !== 3'd2) begin n_fail++; $display("[TB] FAIL single.axis got=%0d exp=2", cmd_axis); end
        if (cmd_neg !== 1'b1)  begin n_fail++; $display("[TB] FAIL single.neg got=%0b exp=1", cmd_neg); end
      end
      if (cmd_valid) hs++;
    end
    n_tests++;
    if (hs < 4) begin n_fail++; $display("[TB] FAIL single.count got=%0d exp>=4", hs); end
    send_byte(8'hF0);
    send_byte(8'h1D);
    repeat (30) begin
      @(negedge clk);
      n_tests += 2;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL release.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (held !== m_held)       begin n_fail++; $display("[TB] FAIL release.held got=%h exp=%h", held, m_held); end
    end
  endtask

  task automatic test_opposing;
    send_byte(8'h1D);
    send_byte(8'h23);
    repeat (40) begin
      @(negedge clk);
      n_tests += 2;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL pair.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (m_valid && {cmd_axis, cmd_neg} !== {m_axis, m_neg}) begin n_fail++; $display("[TB] FAIL pair.cmd got=%0d/%0b exp=%0d/%0b", cmd_axis, cmd_neg, m_axis, m_neg); end
    end
    send_byte(8'h1B);
    repeat (48) begin
      @(negedge clk);
      n_tests += 3;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL cancel.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (held !== m_held)       begin n_fail++; $display("[TB] FAIL cancel.held got=%h exp=%h", held, m_held); end
      if (cmd_valid && cmd_axis !== 3'd0) begin n_fail++; $display("[TB] FAIL cancel.axis got=%0d exp=0", cmd_axis); end
    end
    send_byte(8'hF0); send_byte(8'h1D);
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1B);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_extended;
    send_byte(8'hE0);
    send_byte(8'h75);
    n_tests++;
    if (held !== 12'h040) begin n_fail++; $display("[TB] FAIL ext.make got=%h exp=040", held); end
    repeat (12) begin
      @(negedge clk);
      n_tests++;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL ext.cmd_valid got=%0b exp=%0b", cmd_valid, m_valid); end
      if (m_valid) begin
        n_tests++;
        if ({cmd_axis, cmd_neg} !== {3'd4, 1'b1}) begin n_fail++; $display("[TB] FAIL ext.cmd got=%0d/%0b exp=4/1", cmd_axis, cmd_neg); end
      end
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    n_tests++;
    if (held !== 12'h000) begin n_fail++; $display("[TB] FAIL ext.break got=%h exp=000", held); end
  endtask

  task automatic test_backpressure;
    logic [2:0] axis0;
    @(negedge clk);
    cmd_ready = 1'b0;
    send_byte(8'h1D);
    repeat (40) begin
      @(negedge clk);
      n_tests += 2;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL stall.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (drop_cnt !== m_drop)   begin n_fail++; $display("[TB] FAIL stall.drop got=%0d exp=%0d", drop_cnt, m_drop); end
    end
    n_tests += 2;
    if (drop_cnt < 8'd3 || drop_cnt > 8'd5) begin n_fail++; $display("[TB] FAIL stall.drop_range got=%0d exp=3..5", drop_cnt); end
    axis0 = cmd_axis;
    if (axis0 !== 3'd2) begin n_fail++; $display("[TB] FAIL stall.axis got=%0d exp=2", axis0); end
    send_byte(8'hF0); send_byte(8'h1D);
    n_tests++;
    if (cmd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall.no_retract got=%0b exp=1", cmd_valid); end
    repeat (2400) @(negedge clk);
    n_tests += 2;
    if (drop_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL stall.saturate got=%0d exp=255", drop_cnt); end
    if (drop_cnt !== m_drop) begin n_fail++; $display("[TB] FAIL stall.model_drop got=%0d exp=%0d", drop_cnt, m_drop); end
    cmd_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL drain.cmd_valid got=%0b exp=%0b", cmd_valid, m_valid); end
    end
  endtask

  task automatic test_reset_mid_issue;
    cmd_ready = 1'b0;
    send_byte(8'h1D);
    repeat (16) @(negedge clk);
    n_tests++;
    if (cmd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid.pre_valid got=%0b exp=1", cmd_valid); end
    #2 resetn = 1'b0;
    #1;
    n_tests += 3;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.cmd_valid got=%0b exp=0", cmd_valid); end
    if (held !== 12'h000)   begin n_fail++; $display("[TB] FAIL rst_mid.held got=%h exp=000", held); end
    if (drop_cnt !== 8'd0)  begin n_fail++; $display("[TB] FAIL rst_mid.drop got=%0d exp=0", drop_cnt); end
    @(negedge clk);
    resetn = 1'b1;
    cmd_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      n_tests += 2;
      if (cmd_valid !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_mid.quiet got=%0b exp=0", cmd_valid); end
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rst_mid.model got=%0b exp=%0b", cmd_valid, m_valid); end
    end
  endtask

  task automatic test_random;
    int r;
    repeat (600) begin
      @(negedge clk);
      n_tests += 3;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rand.cmd_valid got=%0b exp=%0b t=%0t", cmd_valid, m_valid, $time); end
      if (held !== m_held)       begin n_fail++; $display("[TB] FAIL rand.held got=%h exp=%h t=%0t", held, m_held, $time); end
      if (drop_cnt !== m_drop)   begin n_fail++; $display("[TB] FAIL rand.drop got=%0d exp=%0d", drop_cnt, m_drop); end
      if (m_valid) begin
        n_tests++;
        if ({cmd_axis, cmd_neg} !== {m_axis, m_neg}) begin n_fail++; $display("[TB] FAIL rand.cmd got=%0d/%0b exp=%0d/%0b", cmd_axis, cmd_neg, m_axis, m_neg); end
      end
      cmd_ready  = ($urandom_range(0, 3) != 0);
      scan_valid = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 15);
      if (r < 12)       scan_code = CODES[r];
      else if (r == 12) scan_code = 8'hE0;
      else if (r < 15)  scan_code = 8'hF0;
      else              scan_code = 8'($urandom);
    end
    scan_valid = 1'b0;
    cmd_ready  = 1'b1;
  endtask

`ifdef POSE_SCHED_ACCEL_EN
  task automatic test_accel;
    int cyc = 0, last_hs = -100, gap = 0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    send_byte(8'h23);
    repeat (220) begin
      @(negedge clk);
      cyc++;
      n_tests++;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL accel.cmd_valid got=%0b exp=%0b", cmd_valid, m_valid); end
      if (cmd_valid) begin gap = cyc - last_hs; last_hs = cyc; end
    end
    n_tests++;
    if (gap !== 2) begin n_fail++; $display("[TB] FAIL accel.fast_gap got=%0d exp=2", gap); end
    send_byte(8'h1D);
    cyc += 2;
    repeat (60) begin
      @(negedge clk);
      cyc++;
      n_tests++;
      if (cmd_valid !== m_valid) begin n_fail++; $display("[TB] FAIL accel.slow_valid got=%0b exp=%0b", cmd_valid, m_valid); end
      if (cmd_valid) begin gap = cyc - last_hs; last_hs = cyc; end
    end
    n_tests++;
    if (gap !== 8) begin n_fail++; $display("[TB] FAIL accel.slow_gap got=%0d exp=8", gap); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_key();
    test_opposing();
    test_extended();
    test_backpressure();
    test_reset_mid_issue();
    test_random();
`ifdef POSE_SCHED_ACCEL_EN
    test_accel();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
